// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one word-aligned memory bus between NUM_REQ
// requesters (0 = MEM-stage D-port, 1 = page-table walker / debug master).
// Round-robin arbitration with zero added latency. The grant is held until
// the handshake completes, and a lock keeps the bus for LR/SC and AMO
// read-modify-write sequences.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     per-requester handshake
//   req_addr/write/wdata/wstrb/lock  packed per-requester payload (i at [i*W +: W])
//   req_rdata           read data broadcast to all requesters
//   req_err             bus error qualified per requester
//   bus_*               system-bus side, valid/ready/err with same-cycle ready
//   gnt_id              current effective grantee (debug)
//
// Build option: define CORE_MEM_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed lowest-index priority in IDLE (no round-robin pointer is kept).
// All outputs are combinational.
module core_mem_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*32-1:0]      req_wdata,
  input  logic [NUM_REQ*4-1:0]       req_wstrb,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [31:0]                req_rdata,
  output logic [NUM_REQ-1:0]         req_err,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic [AW-1:0]              bus_addr,
  output logic                       bus_write,
  output logic [31:0]                bus_wdata,
  output logic [3:0]                 bus_wstrb,
  input  logic [31:0]                bus_rdata,
  input  logic                       bus_err,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] gnt, gnt_nxt;
  logic [IW-1:0] winner, grantee;
  logic          found, active, fire, lock;

`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
  logic [IW-1:0] last, last_nxt;
  int unsigned   idx;
`endif

  // Per-requester views of the packed payload buses
  logic [AW-1:0] addr_a  [NUM_REQ];
  logic [31:0]   wdata_a [NUM_REQ];
  logic [3:0]    wstrb_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*AW +: AW];
    assign wdata_a[i] = req_wdata[i*32 +: 32];
    assign wstrb_a[i] = req_wstrb[i*4 +: 4];
  end

  // IDLE winner selection
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last one assigned
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[IW'(i)]) begin
        winner = IW'(i);
        found  = 1'b1;
      end
    end
`else
    idx = 0;
    // Scan from farthest to nearest so last+1 has final say
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (req_valid[IW'(idx)]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
`endif
  end

  // Bus mux and handshake qualification; reset drops everything at once
  always_comb begin
    grantee   = (state == IDLE) ? winner : gnt;
    active    = ~rst & ((state != IDLE) | found);
    bus_valid = active & req_valid[grantee];
    bus_addr  = active ? addr_a[grantee]    : '0;
    bus_write = active ? req_write[grantee] : 1'b0;
    bus_wdata = active ? wdata_a[grantee]   : '0;
    bus_wstrb = active ? wstrb_a[grantee]   : '0;
    lock      = req_lock[grantee];
    fire      = bus_valid & bus_ready;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = fire & (grantee == IW'(i));
    end
    req_err   = req_ready & {NUM_REQ{bus_err}};
    req_rdata = bus_rdata;
    gnt_id    = grantee;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
    last_nxt  = last;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          if (fire) begin
`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
            last_nxt = winner;
`endif
            if (lock) begin
              state_nxt = LOCKED;
              gnt_nxt   = winner;
            end
          end else begin
            // Freeze the grant so the request stays stable on the bus
            state_nxt = HOLD;
            gnt_nxt   = winner;
          end
        end
      end
      HOLD: begin
        if (!req_valid[gnt]) begin
          state_nxt = IDLE;
        end else if (fire) begin
          if (lock) begin
            state_nxt = LOCKED;
          end else begin
            state_nxt = IDLE;
`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
            last_nxt  = gnt;
`endif
          end
        end
      end
      LOCKED: begin
        if (fire && !lock) begin
          state_nxt = IDLE;
`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
          last_nxt  = gnt;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
      last  <= IW'(NUM_REQ - 1);
`endif
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
      last  <= last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter (NUM_REQ=2, AW=32).
module tb_core_mem_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_write;
  logic [NR*32-1:0]  req_wdata;
  logic [NR*4-1:0]   req_wstrb;
  logic [NR-1:0]     req_lock;
  logic [31:0]       req_rdata;
  logic [NR-1:0]     req_err;
  logic              bus_valid;
  logic              bus_ready;
  logic [AW-1:0]     bus_addr;
  logic              bus_write;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_rdata;
  logic              bus_err;
  logic [0:0]        gnt_id;

  int n_cmp = 0;
  int n_bad = 0;

  core_mem_arbiter #(.NUM_REQ(NR), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_lock(req_lock), .req_rdata(req_rdata), .req_err(req_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program one requester's payload; wdata is derived from the address
  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic w, input logic lk);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = w;
    req_wdata[i*32 +: 32] = {a[15:0], ~a[15:0]};
    req_wstrb[i*4 +: 4]   = w ? 4'hF : 4'h0;
    req_lock[i]           = lk;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    req_wstrb = '0; req_lock = '0;
    bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_cmp++;
    if ({bus_valid, req_ready, req_err, gnt_id} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b expected %b", {bus_valid, req_ready, req_err, gnt_id}, 6'b0);
    end
    n_cmp++;
    if (bus_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_addr: got %h expected %h", bus_addr, 32'h0);
    end
  endtask

  task automatic test_round_robin();
    logic [0:0]  eg [3];
    logic [31:0] ea [3];
    do_reset();
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
    eg[0] = 1'b0; eg[1] = 1'b0; eg[2] = 1'b0;
`else
    eg[0] = 1'b0; eg[1] = 1'b1; eg[2] = 1'b0;
`endif
    for (int c = 0; c < 3; c++) ea[c] = eg[c] ? 32'h200 : 32'h100;
    set_req(0, 1'b1, 32'h100, 1'b0, 1'b0);
    set_req(1, 1'b1, 32'h200, 1'b1, 1'b0);
    bus_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++;
      if ({bus_valid, bus_write, gnt_id, req_ready} !==
          {1'b1, eg[c], eg[c], (eg[c] ? 2'b10 : 2'b01)}) begin
        n_bad++;
        $display("FAIL rr_c%0d: got v/w/g/rdy %b expected %b", c,
                 {bus_valid, bus_write, gnt_id, req_ready},
                 {1'b1, eg[c], eg[c], (eg[c] ? 2'b10 : 2'b01)});
      end
      n_cmp++;
      if (bus_addr !== ea[c] || (eg[c] && (bus_wdata !== 32'h0200FDFF || bus_wstrb !== 4'hF))) begin
        n_bad++;
        $display("FAIL rr_data_c%0d: got addr %h wdata %h wstrb %h expected addr %h", c,
                 bus_addr, bus_wdata, bus_wstrb, ea[c]);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_req(1, 1'b1, 32'h40, 1'b0, 1'b0);
    bus_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) set_req(0, 1'b1, 32'h100, 1'b0, 1'b0);
      if (c == 3) bus_ready = 1'b1;
      #2;
      n_cmp++;
      if ({bus_valid, bus_addr, gnt_id, req_ready} !==
          {1'b1, 32'h40, 1'b1, (c == 3 ? 2'b10 : 2'b00)}) begin
        n_bad++;
        $display("FAIL hold_c%0d: got v %b addr %h g %b rdy %b expected addr 40 g 1 rdy %b", c,
                 bus_valid, bus_addr, gnt_id, req_ready, (c == 3 ? 2'b10 : 2'b00));
      end
      tick();
    end
    req_valid[1] = 1'b0;
    #2;
    n_cmp++;
    if ({bus_addr, gnt_id, req_ready} !== {32'h100, 1'b0, 2'b01}) begin
      n_bad++;
      $display("FAIL hold_next: got addr %h g %b rdy %b expected addr 100 g 0 rdy 01",
               bus_addr, gnt_id, req_ready);
    end
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    bus_ready = 1'b1;
    set_req(0, 1'b1, 32'h300, 1'b0, 1'b1);
    #2;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL lock_lr: got rdy %b expected 01", req_ready);
    end
    tick();
    set_req(0, 1'b0, 32'h300, 1'b0, 1'b0);
    set_req(1, 1'b1, 32'h200, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #2;
      n_cmp++;
      if ({bus_valid, req_ready, gnt_id} !== 4'b0000) begin
        n_bad++;
        $display("FAIL lock_block_c%0d: got v/rdy/g %b expected 0000", c,
                 {bus_valid, req_ready, gnt_id});
      end
      tick();
    end
    set_req(0, 1'b1, 32'h304, 1'b1, 1'b0);
    #2;
    n_cmp++;
    if ({bus_addr, bus_write, req_ready} !== {32'h304, 1'b1, 2'b01}) begin
      n_bad++;
      $display("FAIL lock_sc: got addr %h w %b rdy %b expected addr 304 w 1 rdy 01",
               bus_addr, bus_write, req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    #2;
    n_cmp++;
    if ({bus_addr, gnt_id, req_ready} !== {32'h200, 1'b1, 2'b10}) begin
      n_bad++;
      $display("FAIL lock_release: got addr %h g %b rdy %b expected addr 200 g 1 rdy 10",
               bus_addr, gnt_id, req_ready);
    end
    tick();
  endtask

  task automatic test_error();
    do_reset();
    bus_ready = 1'b1;
    bus_err   = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    #2;
    n_cmp++;
    if ({bus_valid, req_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL err_idle: got v %b err %b expected v 0 err 00", bus_valid, req_err);
    end
    set_req(0, 1'b1, 32'h100, 1'b0, 1'b0);
    #2;
    n_cmp++;
    if ({req_ready, req_err, req_rdata} !== {2'b01, 2'b01, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL err_hit: got rdy %b err %b rdata %h expected 01 01 deadbeef",
               req_ready, req_err, req_rdata);
    end
    tick();
    bus_err   = 1'b0;
    bus_rdata = 32'h12345678;
    #2;
    n_cmp++;
    if ({req_ready, req_err, req_rdata} !== {2'b01, 2'b00, 32'h12345678}) begin
      n_bad++;
      $display("FAIL err_after: got rdy %b err %b rdata %h expected 01 00 12345678",
               req_ready, req_err, req_rdata);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [0:0] ew;
    do_reset();
    bus_ready = 1'b1;
    set_req(0, 1'b1, 32'h100, 1'b0, 1'b0);
    tick();
    req_valid[0] = 1'b0;
    bus_ready    = 1'b0;
    set_req(1, 1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    req_valid[1] = 1'b0;
    #2;
    n_cmp++;
    if ({bus_valid, req_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL flush_drop: got v %b rdy %b expected 0 00", bus_valid, req_ready);
    end
    tick();
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
    ew = 1'b0;
`else
    ew = 1'b1;
`endif
    req_valid = 2'b11;
    bus_ready = 1'b1;
    #2;
    n_cmp++;
    if ({gnt_id, req_ready} !== {ew, (ew ? 2'b10 : 2'b01)}) begin
      n_bad++;
      $display("FAIL flush_ptr: got g %b rdy %b expected g %b", gnt_id, req_ready, ew);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    bus_ready = 1'b0;
    set_req(1, 1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    #2;
    n_cmp++;
    if ({bus_valid, gnt_id} !== 2'b11) begin
      n_bad++;
      $display("FAIL rsthold_pre: got v %b g %b expected 1 1", bus_valid, gnt_id);
    end
    rst       = 1'b1;
    bus_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus_valid, req_ready, bus_addr} !== {1'b0, 2'b00, 32'h0}) begin
      n_bad++;
      $display("FAIL rsthold_drop: got v %b rdy %b addr %h expected 0 00 0",
               bus_valid, req_ready, bus_addr);
    end
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 32'h100, 1'b0, 1'b0);
    #2;
    n_cmp++;
    if ({bus_valid, gnt_id, req_ready, bus_addr} !== {1'b1, 1'b0, 2'b01, 32'h100}) begin
      n_bad++;
      $display("FAIL rsthold_after: got v %b g %b rdy %b addr %h expected 1 0 01 100",
               bus_valid, gnt_id, req_ready, bus_addr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_lock();
    test_error();
    test_flush();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
